// File: rtl/uart_bridge_pkg.sv
// rtl/uart_bridge_pkg.sv - shared state encodings and RX entry layout for the UART host bridge
package uart_bridge_pkg;

  // Transmit side: hand one byte to the UART, then follow t_empty through accept and drain.
  typedef enum logic [1:0] {
    TX_IDLE,
    TX_STROBE,
    TX_ACK,
    TX_DRAIN
  } tx_state_t;

  // Receive side: capture, strobe rdn once, then wait for the UART to drop r_ready.
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_STROBE,
    RX_WAIT
  } rx_state_t;

  localparam int RX_DATA_LSB = 0;
  localparam int RX_DATA_MSB = 7;
  localparam int RX_PERR_BIT = 8;
  localparam int RX_FERR_BIT = 9;
  localparam int RX_ENTRY_W  = 10;

  // Build an RX FIFO entry from the UART's byte and error flags.
  function automatic logic [RX_ENTRY_W-1:0] pack_rx_entry(input logic ferr,
                                                          input logic perr,
                                                          input logic [7:0] data);
    logic [RX_ENTRY_W-1:0] e;
    e = '0;
    e[RX_DATA_MSB:RX_DATA_LSB] = data;
    e[RX_PERR_BIT] = perr;
    e[RX_FERR_BIT] = ferr;
    return e;
  endfunction

endpackage

// File: rtl/uart_host_bridge_if.sv
// rtl/uart_host_bridge_if.sv - host stream and UART CPU handshake bundle for the bridge
interface uart_host_bridge_if;
  // host transmit stream
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  // host receive stream
  logic [7:0] rx_data;
  logic       rx_perr;
  logic       rx_ferr;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_overrun;
  logic       ovr_clr;
  // UART transmitter handshake
  logic       wrn;
  logic [7:0] d_in;
  logic       t_empty;
  // UART receiver handshake
  logic       rdn;
  logic [7:0] d_out;
  logic       r_ready;
  logic       parity_error;
  logic       frame_error;

  // The bridge itself.
  modport slave (
    input  tx_data, tx_valid, rx_ready, ovr_clr,
    input  t_empty, d_out, r_ready, parity_error, frame_error,
    output tx_ready, rx_data, rx_perr, rx_ferr, rx_valid, rx_overrun,
    output wrn, d_in, rdn
  );

  // Host logic plus the UART on the far side.
  modport master (
    output tx_data, tx_valid, rx_ready, ovr_clr,
    output t_empty, d_out, r_ready, parity_error, frame_error,
    input  tx_ready, rx_data, rx_perr, rx_ferr, rx_valid, rx_overrun,
    input  wrn, d_in, rdn
  );
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with combinational head and push-through-on-pop when full
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic             clk16x,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [CW-1:0]         count;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push onto a full FIFO still lands.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage is cleared on reset so the head reads zero while empty.
  always_ff @(posedge clk16x or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally mod DEPTH; count tracks occupancy.
  always_ff @(posedge clk16x or posedge clr) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (do_pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/uart_host_bridge.sv
// rtl/uart_host_bridge.sv - buffers host bytes to/from the UART CPU handshake through two FIFOs
module uart_host_bridge #(
  parameter int DEPTH_LOG2 = 3,
  parameter int WR_PULSE   = 2
) (
  input  logic              clk16x,
  input  logic              clr,
  uart_host_bridge_if.slave bus
);
  import uart_bridge_pkg::*;

  localparam int CNT_W = (WR_PULSE > 1) ? $clog2(WR_PULSE) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WR_PULSE - 1);

  tx_state_t             tx_state;
  rx_state_t             rx_state;
  logic [CNT_W-1:0]      strobe_cnt;
  logic                  wrn_q;
  logic                  rdn_q;
  logic [7:0]            d_in_q;
  logic                  overrun_q;
  logic [RX_ENTRY_W-1:0] rx_cap;

  logic                  tx_full;
  logic                  tx_fifo_empty;
  logic [7:0]            tx_head;
  logic                  tx_push;
  logic                  tx_pop;

  logic                  rx_full;
  logic                  rx_fifo_empty;
  logic [RX_ENTRY_W-1:0] rx_head;
  logic                  rx_push;
  logic                  rx_drop;

  assign tx_push = bus.tx_valid & ~tx_full;
  assign tx_pop  = (tx_state == TX_IDLE) & ~tx_fifo_empty & bus.t_empty;

  // The captured entry is pushed during the single rdn-low cycle.
  assign rx_push = (rx_state == RX_STROBE);
  assign rx_drop = rx_push & rx_full & ~bus.rx_ready;

  sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk16x (clk16x),
    .clr    (clr),
    .push   (tx_push),
    .wdata  (bus.tx_data),
    .pop    (tx_pop),
    .rdata  (tx_head),
    .full   (tx_full),
    .empty  (tx_fifo_empty)
  );

  sync_fifo #(.WIDTH(RX_ENTRY_W), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk16x (clk16x),
    .clr    (clr),
    .push   (rx_push),
    .wdata  (rx_cap),
    .pop    (bus.rx_ready),
    .rdata  (rx_head),
    .full   (rx_full),
    .empty  (rx_fifo_empty)
  );

  // TX FSM: pop one byte, hold wrn low WR_PULSE cycles, then track t_empty low and back high.
  always_ff @(posedge clk16x or posedge clr) begin
    if (clr) begin
      tx_state   <= TX_IDLE;
      wrn_q      <= 1'b1;
      d_in_q     <= '0;
      strobe_cnt <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_pop) begin
            d_in_q     <= tx_head;
            wrn_q      <= 1'b0;
            strobe_cnt <= '0;
            tx_state   <= TX_STROBE;
          end
        end
        TX_STROBE: begin
          if (strobe_cnt == LAST_CNT) begin
            wrn_q    <= 1'b1;
            tx_state <= TX_ACK;
          end else begin
            strobe_cnt <= strobe_cnt + CNT_W'(1);
          end
        end
        TX_ACK: begin
          if (!bus.t_empty) tx_state <= TX_DRAIN;
        end
        TX_DRAIN: begin
          if (bus.t_empty) tx_state <= TX_IDLE;
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // RX FSM: capture on r_ready, strobe rdn for one cycle, and refuse to re-read until r_ready drops.
  always_ff @(posedge clk16x or posedge clr) begin
    if (clr) begin
      rx_state <= RX_IDLE;
      rdn_q    <= 1'b1;
      rx_cap   <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (bus.r_ready) begin
            rx_cap   <= pack_rx_entry(bus.frame_error, bus.parity_error, bus.d_out);
            rdn_q    <= 1'b0;
            rx_state <= RX_STROBE;
          end
        end
        RX_STROBE: begin
          rdn_q    <= 1'b1;
          rx_state <= RX_WAIT;
        end
        RX_WAIT: begin
          if (!bus.r_ready) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Sticky overrun: a dropped byte wins over a same-cycle clear.
  always_ff @(posedge clk16x or posedge clr) begin
    if (clr) begin
      overrun_q <= 1'b0;
    end else if (rx_drop) begin
      overrun_q <= 1'b1;
    end else if (bus.ovr_clr) begin
      overrun_q <= 1'b0;
    end
  end

  assign bus.wrn        = wrn_q;
  assign bus.d_in       = d_in_q;
  assign bus.rdn        = rdn_q;
  assign bus.tx_ready   = ~tx_full;
  assign bus.rx_valid   = ~rx_fifo_empty;
  assign bus.rx_data    = rx_head[RX_DATA_MSB:RX_DATA_LSB];
  assign bus.rx_perr    = rx_head[RX_PERR_BIT];
  assign bus.rx_ferr    = rx_head[RX_FERR_BIT];
  assign bus.rx_overrun = overrun_q;
endmodule
